// File: rtl/iua_cmd_pkg.sv
// Shared definitions for the analyzer host command processor: opcodes,
// FSM state encodings and the layout of the status response byte.
package iua_cmd_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_STOP    = 8'h01;
  localparam logic [7:0] OP_START   = 8'h02;
  localparam logic [7:0] OP_FLUSH   = 8'h03;
  localparam logic [7:0] OP_SET_DIV = 8'h04;
  localparam logic [7:0] OP_ID      = 8'h05;

  typedef enum logic [1:0] {
    PS_IDLE   = 2'd0,
    PS_DIV_LO = 2'd1,
    PS_DIV_HI = 2'd2
  } parse_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_FIFO = 2'd1,
    SRC_RESP = 2'd2
  } tx_src_e;

  localparam int STAT_CAP_EN_BIT = 0;
  localparam int STAT_EMPTY_BIT  = 1;
  localparam int STAT_ERR_BIT    = 2;

  function automatic logic [7:0] pack_status(input logic err,
                                             input logic fifo_empty,
                                             input logic cap_en);
    logic [7:0] s;
    s                  = '0;
    s[STAT_ERR_BIT]    = err;
    s[STAT_EMPTY_BIT]  = fifo_empty;
    s[STAT_CAP_EN_BIT] = cap_en;
    return s;
  endfunction

endpackage

// File: rtl/iua_cmd_resp_buf.sv
// Two-entry byte FIFO holding pending command response bytes until the
// TX arbiter hands them to the UART.
module iua_cmd_resp_buf
  import iua_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  always_comb begin
    empty_o = (count_q == 2'd0);
    full_o  = (count_q == 2'd2);
    pop_ok  = pop_i && !empty_o;
    // A push into a full buffer is accepted only when a pop frees a slot.
    push_ok = push_i && (!full_o || pop_ok);
    head_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/iua_cmd_ctrl.sv
// Host command parser and TX stream arbiter: decodes UART command bytes into
// capture control and merges command responses with captured FIFO data.
module iua_cmd_ctrl
  import iua_cmd_pkg::*;
#(
  parameter int         DIV_WIDTH   = 8,
  parameter int         DIV_DEFAULT = 16,
  parameter logic [7:0] ID_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic [7:0]           fifo_do,
  input  logic                 fifo_empty,
  output logic                 fifo_rden,
  output logic                 fifo_flush,
  output logic                 cap_en,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ack,
  output logic [DIV_WIDTH-1:0] div
);

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_DEFAULT);
  localparam int                   TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(TIMEOUT_CYC);

  parse_state_e         ps_q;
  logic                 cap_en_q;
  logic                 flush_q;
  logic                 err_q;
  logic                 stat_push_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_word;
  logic [7:0]           lo_q;
  logic [7:0]           stat_q;
  logic [TMO_W-1:0]     tmo_q;

  logic op_fire;
  logic id_cmd;
  logic id_push;
  logic id_drop;
  logic bad_op;
  logic div_zero;
  logic tmo_hit;
  logic err_set;
  logic resp_busy;

  tx_src_e    src_q;
  tx_src_e    src_d;
  logic       rb_push;
  logic       rb_pop;
  logic       rb_full;
  logic       rb_empty;
  logic [7:0] rb_push_data;
  logic [7:0] rb_head;
  logic       slot_free;
  logic       resp_next;

  always_comb begin
    op_fire   = rx_valid && (ps_q == PS_IDLE);
    id_cmd    = op_fire && (rx_data == OP_ID);
    // The status byte is queued one cycle after the ID byte, so that cycle counts as busy.
    resp_busy = !rb_empty || stat_push_q;
    id_push   = id_cmd && !resp_busy;
    id_drop   = id_cmd && resp_busy;
    bad_op    = op_fire && (rx_data > OP_ID);
    div_word  = DIV_WIDTH'({rx_data, lo_q});
    div_zero  = rx_valid && (ps_q == PS_DIV_HI) && (div_word == '0);
    tmo_hit   = !rx_valid && (ps_q != PS_IDLE) && (tmo_q == TMO_MAX);
    err_set   = bad_op || id_drop || div_zero || tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q        <= PS_IDLE;
      cap_en_q    <= 1'b0;
      div_q       <= DIV_RST;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      stat_push_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      flush_q     <= 1'b0;
      stat_push_q <= id_push;
      // A new error in the cycle the status is queued must survive the clear.
      err_q       <= (err_q && !stat_push_q) || err_set;
      if (rx_valid || (ps_q == PS_IDLE)) tmo_q <= '0;
      else if (tmo_q != TMO_MAX)         tmo_q <= tmo_q + 1'b1;
      case (ps_q)
        PS_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OP_NOP:     ;
              OP_STOP:    cap_en_q <= 1'b0;
              OP_START:   cap_en_q <= 1'b1;
              OP_FLUSH:   flush_q  <= 1'b1;
              OP_SET_DIV: ps_q     <= PS_DIV_LO;
              default:    ;
            endcase
          end
        end
        PS_DIV_LO: begin
          if (rx_valid)     ps_q <= PS_DIV_HI;
          else if (tmo_hit) ps_q <= PS_IDLE;
        end
        PS_DIV_HI: begin
          if (rx_valid) begin
            ps_q <= PS_IDLE;
            if (!div_zero) div_q <= div_word;
          end else if (tmo_hit) begin
            ps_q <= PS_IDLE;
          end
        end
        default: ps_q <= PS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_valid && (ps_q == PS_DIV_LO)) lo_q <= rx_data;
    if (id_push) stat_q <= pack_status(err_q, fifo_empty, cap_en_q);
  end

  iua_cmd_resp_buf u_resp_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rb_push),
    .push_data_i (rb_push_data),
    .pop_i       (rb_pop),
    .head_o      (rb_head),
    .full_o      (rb_full),
    .empty_o     (rb_empty)
  );

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    case (src_q)
      SRC_FIFO: begin
        // A flush kills the pending FIFO byte in the same cycle.
        tx_valid = !fifo_empty && !flush_q;
        tx_data  = fifo_do;
      end
      SRC_RESP: begin
        tx_valid = !rb_empty;
        tx_data  = rb_head;
      end
      default: ;
    endcase
    rb_pop       = (src_q == SRC_RESP) && tx_ack && !rb_empty;
    fifo_rden    = (src_q == SRC_FIFO) && tx_ack && tx_valid;
    rb_push      = id_push || stat_push_q;
    rb_push_data = stat_push_q ? stat_q : ID_BYTE;
    slot_free    = !tx_valid || tx_ack;
    // Includes bytes pushed this cycle so a fresh response wins the next slot.
    resp_next    = rb_full || (!rb_empty && !rb_pop) || rb_push;
    src_d        = src_q;
    if (flush_q && (src_q == SRC_FIFO)) begin
      src_d = SRC_NONE;
    end else if (slot_free) begin
      if (resp_next)                    src_d = SRC_RESP;
      else if (!fifo_empty && !flush_q) src_d = SRC_FIFO;
      else                              src_d = SRC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) src_q <= SRC_NONE;
    else     src_q <= src_d;
  end

  assign cap_en     = cap_en_q;
  assign div        = div_q;
  assign fifo_flush = flush_q;

endmodule

// File: tb/tb_iua_cmd_ctrl.sv
// Directed bench for iua_cmd_ctrl: a small FWFT FIFO model feeds the DUT and
// every TX byte, divider value and strobe is compared with hand-derived values.
`timescale 1ns/1ps
module tb_iua_cmd_ctrl;

  localparam int TMO = 40;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ack   = 1'b0;
  logic [7:0]  fifo_do;
  logic        fifo_empty;

  logic        fifo_rden, fifo_flush, cap_en, tx_valid;
  logic [7:0]  tx_data;
  logic [7:0]  div8;
  logic        fifo_rden16, fifo_flush16, cap_en16, tx_valid16;
  logic [7:0]  tx_data16;
  logic [15:0] div16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iua_cmd_ctrl #(.DIV_WIDTH(8), .DIV_DEFAULT(16), .ID_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .fifo_flush(fifo_flush), .cap_en(cap_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ack(tx_ack), .div(div8)
  );

  iua_cmd_ctrl #(.DIV_WIDTH(16), .DIV_DEFAULT(16), .ID_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut16 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden16),
    .fifo_flush(fifo_flush16), .cap_en(cap_en16), .tx_data(tx_data16),
    .tx_valid(tx_valid16), .tx_ack(tx_ack), .div(div16)
  );

  // First-word-fall-through FIFO model driven by the 8-bit instance
  logic [7:0] fmem [0:7];
  logic [3:0] f_rd = 4'd0;
  logic [3:0] f_wr = 4'd0;
  logic       push_en   = 1'b0;
  logic [7:0] push_byte = 8'h00;

  always @(posedge clk) begin
    if (fifo_flush) begin
      f_rd <= 4'd0;
      f_wr <= 4'd0;
    end else begin
      if (fifo_rden) f_rd <= f_rd + 4'd1;
      if (push_en) begin
        fmem[f_wr[2:0]] <= push_byte;
        f_wr <= f_wr + 4'd1;
      end
    end
  end

  assign fifo_empty = (f_rd == f_wr);
  assign fifo_do    = fmem[f_rd[2:0]];

  int   rden_cnt   = 0;
  int   rden_empty = 0;
  int   twin_diff  = 0;
  int   stab_viol  = 0;
  logic stab_en    = 1'b0;
  logic pv = 1'b0, pa = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(posedge clk) begin
    if (fifo_rden) rden_cnt <= rden_cnt + 1;
    if (fifo_rden && fifo_empty) rden_empty <= rden_empty + 1;
    if ({fifo_rden16, fifo_flush16, cap_en16, tx_valid16, tx_data16} !==
        {fifo_rden, fifo_flush, cap_en, tx_valid, tx_data})
      twin_diff <= twin_diff + 1;
    if (stab_en && pv && !pa && (!tx_valid || (tx_data != pd)))
      stab_viol <= stab_viol + 1;
    pv <= tx_valid;
    pd <= tx_data;
    pa <= tx_ack;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_fifo(input logic [7:0] b);
    @(negedge clk);
    push_en   = 1'b1;
    push_byte = b;
    @(negedge clk);
    push_en   = 1'b0;
  endtask

  // Waits (bounded) for a byte, checks it and acknowledges it for one cycle.
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, {31'd0, tx_valid}, 32'd1);
    check(tag, {24'd0, tx_data}, {24'd0, exp});
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp7 [5];
    int r0;
    exp7 = '{8'h11, 8'hA5, 8'h01, 8'h22, 8'h33};

    repeat (3) @(negedge clk);
    check("rst_cap_en",   {31'd0, cap_en},     32'd0);
    check("rst_div8",     {24'd0, div8},       32'd16);
    check("rst_div16",    {16'd0, div16},      32'd16);
    check("rst_flush",    {31'd0, fifo_flush}, 32'd0);
    check("rst_rden",     {31'd0, fifo_rden},  32'd0);
    check("rst_tx_valid", {31'd0, tx_valid},   32'd0);
    check("rst_tx_data",  {24'd0, tx_data},    32'd0);
    rst = 1'b0;

    // START / STOP
    send_rx(8'h02);
    check("start_cap_en", {31'd0, cap_en}, 32'd1);
    check("start_div8",   {24'd0, div8},   32'd16);
    send_rx(8'h01);
    check("stop_cap_en",  {31'd0, cap_en}, 32'd0);
    check("stop_div8",    {24'd0, div8},   32'd16);

    // SET_DIV 0x1234: full value on the wide instance, low byte on the narrow one
    send_rx(8'h04);
    send_rx(8'h34);
    check("div_mid_div8", {24'd0, div8}, 32'd16);
    send_rx(8'h12);
    check("div_set_div8",  {24'd0, div8},   32'h34);
    check("div_set_div16", {16'd0, div16},  32'h1234);

    // SET_DIV 0 is rejected and flags err
    send_rx(8'h04);
    send_rx(8'h00);
    send_rx(8'h00);
    check("div0_div8",  {24'd0, div8},  32'h34);
    check("div0_div16", {16'd0, div16}, 32'h1234);
    send_rx(8'h05);
    expect_tx("id1_b0", 8'hA5);
    expect_tx("id1_stat", 8'h06);

    // Argument timeout: parser back in IDLE, div kept, err reported
    send_rx(8'h02);
    send_rx(8'h04);
    send_rx(8'h34);
    repeat (TMO + 5) @(negedge clk);
    check("tmo_div8", {24'd0, div8}, 32'h34);
    send_rx(8'h05);
    check("tmo_id_div8",  {24'd0, div8},  32'h34);
    check("tmo_id_div16", {16'd0, div16}, 32'h1234);
    expect_tx("id2_b0", 8'hA5);
    expect_tx("id2_stat", 8'h07);

    // Two IDs before any ack: second dropped, err shows in the next status
    send_rx(8'h05);
    send_rx(8'h05);
    expect_tx("dbl_b0", 8'hA5);
    expect_tx("dbl_stat", 8'h03);
    repeat (5) @(negedge clk);
    check("dbl_no_third", {31'd0, tx_valid}, 32'd0);
    send_rx(8'h05);
    expect_tx("dbl_next_b0", 8'hA5);
    expect_tx("dbl_next_stat", 8'h07);

    // Arbitration: ID arrives while D0 is pending, so the response takes the
    // slot freed by D0's ack; acks spaced 10 cycles apart.
    stab_en = 1'b1;
    r0 = rden_cnt;
    push_fifo(8'h11);
    push_fifo(8'h22);
    push_fifo(8'h33);
    repeat (2) @(negedge clk);
    check("arb_d0_vld",  {31'd0, tx_valid}, 32'd1);
    check("arb_d0_data", {24'd0, tx_data},  32'h11);
    send_rx(8'h05);
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      expect_tx($sformatf("arb_byte%0d", i), exp7[i]);
    end
    repeat (3) @(negedge clk);
    check("arb_idle_vld", {31'd0, tx_valid}, 32'd0);
    check("arb_rden_cnt", rden_cnt - r0, 32'd3);
    stab_en = 1'b0;

    // FLUSH with a FIFO byte pending; ack held high to confirm no pop
    push_fifo(8'h44);
    push_fifo(8'h55);
    repeat (3) @(negedge clk);
    check("fl_pend_vld",  {31'd0, tx_valid}, 32'd1);
    check("fl_pend_data", {24'd0, tx_data},  32'h44);
    r0 = rden_cnt;
    send_rx(8'h03);
    tx_ack = 1'b1;
    #1;
    check("fl_pulse",    {31'd0, fifo_flush}, 32'd1);
    check("fl_tx_valid", {31'd0, tx_valid},   32'd0);
    check("fl_rden",     {31'd0, fifo_rden},  32'd0);
    check("fl_cap_en",   {31'd0, cap_en},     32'd1);
    @(negedge clk);
    tx_ack = 1'b0;
    check("fl_pulse_end", {31'd0, fifo_flush}, 32'd0);
    check("fl_after_vld", {31'd0, tx_valid},   32'd0);
    check("fl_rden_cnt",  rden_cnt - r0,       32'd0);

    // Reset mid SET_DIV discards the argument; then an unknown opcode sets err
    send_rx(8'h04);
    send_rx(8'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_div8",   {24'd0, div8},   32'd16);
    check("mrst_cap_en", {31'd0, cap_en}, 32'd0);
    send_rx(8'h09);
    send_rx(8'h05);
    check("mrst_id_div8", {24'd0, div8}, 32'd16);
    expect_tx("mrst_b0", 8'hA5);
    expect_tx("mrst_stat", 8'h06);

    repeat (2) @(negedge clk);
    check("rden_on_empty", rden_empty, 32'd0);
    check("tx_stable",     stab_viol,  32'd0);
    check("twin_match",    twin_diff,  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
